// File: rtl/fir_pkg.sv
// Shared types, defaults and coefficient sets for the decimating FIR stage.
package fir_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned QUANT_BITS = 10;
  localparam int unsigned LPR_TAPS   = 32;

  typedef logic signed [DATA_WIDTH-1:0] coeff_t;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Symmetric low-pass, Q10 fixed point.
  localparam coeff_t LPR_COEFFS [LPR_TAPS] = '{
    -2, -4, -6, -7, -5, 0, 9, 21, 36, 52, 67, 80, 90, 96, 99, 100,
    100, 99, 96, 90, 80, 67, 52, 36, 21, 9, 0, -5, -7, -6, -4, -2
  };

  // Default-width dequantise: arithmetic shift (floor), truncated to a sample.
  function automatic coeff_t deq(input logic signed [2*DATA_WIDTH-1:0] p);
    return coeff_t'(p >>> QUANT_BITS);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Time-shared multiply / dequantise / accumulate unit with clear and enable.
module fir_mac #(
  parameter int unsigned DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int unsigned QUANT_BITS = fir_pkg::QUANT_BITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] c_i,
  output logic [DATA_WIDTH-1:0] sum_c
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]         prod_c;
  logic        [DATA_WIDTH-1:0] term_c;
  logic        [DATA_WIDTH-1:0] acc_q, acc_d;

  // Full-precision product, floor-shifted back to sample scale; sum wraps.
  always_comb begin
    prod_c = PW'($signed(x_i)) * PW'($signed(c_i));
    term_c = DATA_WIDTH'(prod_c >>> QUANT_BITS);
    sum_c  = acc_q + term_c;
    acc_d  = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_c;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_decim.sv
// Decimating FIR: pops DECIM samples from upstream, runs TAPS MAC cycles on the
// history, then pushes one filtered sample downstream.
module fir_decim #(
  parameter int unsigned DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int unsigned QUANT_BITS = fir_pkg::QUANT_BITS,
  parameter int unsigned TAPS       = fir_pkg::LPR_TAPS,
  parameter int unsigned DECIM      = 8,
  parameter logic signed [DATA_WIDTH-1:0] COEFFS [TAPS] = fir_pkg::LPR_COEFFS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  import fir_pkg::*;

  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned K_W   = $clog2(TAPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(TAPS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [DATA_WIDTH-1:0]   hist_q [TAPS];
  logic [DATA_WIDTH-1:0]   tap_x_c, tap_c_c, sum_c;
  logic                    pop_c, push_c, mac_clr_c, mac_en_c;

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    out_d     = out_q;
    pop_c     = 1'b0;
    push_c    = 1'b0;
    mac_clr_c = 1'b0;
    mac_en_c  = 1'b0;
    case (state_q)
      S_LOAD: begin
        pop_c = ~in_empty;
        if (pop_c) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            k_d       = '0;
            mac_clr_c = 1'b1;
            state_d   = S_MAC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        mac_en_c = 1'b1;
        k_d      = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          out_d   = sum_c;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        push_c = ~out_full;
        if (push_c) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      k_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      out_q   <= out_d;
    end
  end

  // History shift register, x[0] newest; frozen outside pops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        hist_q[i] <= '0;
      end
    end else if (pop_c) begin
      hist_q[0] <= in_dout;
      for (int i = 1; i < int'(TAPS); i++) begin
        hist_q[i] <= hist_q[i-1];
      end
    end
  end

  always_comb begin
    tap_x_c = hist_q[k_q];
    tap_c_c = COEFFS[k_q];
  end

  fir_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .QUANT_BITS (QUANT_BITS)
  ) u_mac (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (mac_clr_c),
    .en_i    (mac_en_c),
    .x_i     (tap_x_c),
    .c_i     (tap_c_c),
    .sum_c   (sum_c)
  );

  // Reset forces the fifo strobes low even though the FSM idles in S_LOAD.
  assign in_rd_en  = pop_c & reset_n;
  assign out_wr_en = push_c & reset_n;
  assign out_din   = out_q;

endmodule

// File: tb/tb_fir_decim.sv
// Scoreboard bench for fir_decim: a main instance (TAPS=4, DECIM=2) and a
// floor-rounding instance (DECIM=1, single half-weight tap).
module tb_fir_decim;

  localparam int unsigned DW    = 32;
  localparam int unsigned QB    = 10;
  localparam int unsigned TAPS  = 4;
  localparam int unsigned DECIM = 2;
  localparam logic signed [DW-1:0] C_MAIN [TAPS] = '{1024, 2048, 3072, 4096};
  localparam logic signed [DW-1:0] C_RND  [TAPS] = '{512, 0, 0, 0};

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] in_dout = '0;
  logic          in_empty = 1'b1;
  logic          in_rd_en;
  logic [DW-1:0] out_din;
  logic          out_full = 1'b0;
  logic          out_wr_en;

  logic [DW-1:0] r_in_dout = '0;
  logic          r_in_empty = 1'b1;
  logic          r_in_rd_en;
  logic [DW-1:0] r_out_din;
  logic          r_out_full = 1'b0;
  logic          r_out_wr_en;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] in_q[$], stream[$], exp_q[$];
  logic [DW-1:0] r_in_q[$], r_exp_q[$];
  bit            stall_in = 1'b0;
  bit            pop_seen = 1'b0;
  bit            r_pop_seen = 1'b0;

  always #5 clock = ~clock;

  fir_decim #(
    .DATA_WIDTH (DW), .QUANT_BITS (QB), .TAPS (TAPS), .DECIM (DECIM), .COEFFS (C_MAIN)
  ) dut (
    .clock (clock), .reset_n (reset_n),
    .in_dout (in_dout), .in_empty (in_empty), .in_rd_en (in_rd_en),
    .out_din (out_din), .out_full (out_full), .out_wr_en (out_wr_en)
  );

  fir_decim #(
    .DATA_WIDTH (DW), .QUANT_BITS (QB), .TAPS (TAPS), .DECIM (1), .COEFFS (C_RND)
  ) dut_r (
    .clock (clock), .reset_n (reset_n),
    .in_dout (r_in_dout), .in_empty (r_in_empty), .in_rd_en (r_in_rd_en),
    .out_din (r_out_din), .out_full (r_out_full), .out_wr_en (r_out_wr_en)
  );

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] deq_ref(input longint c, input longint x);
    longint p;
    p = c * x;
    return DW'(p >>> QB);
  endfunction

  // y = sum_k deq(c[k] * x[n-k]) over everything fed since reset, wrapping mod 2^32
  function automatic logic [DW-1:0] fir_ref();
    logic [DW-1:0] acc;
    int n;
    acc = '0;
    n = stream.size();
    for (int k = 0; k < int'(TAPS); k++) begin
      if (n - 1 - k >= 0)
        acc = acc + deq_ref(longint'(C_MAIN[k]), longint'($signed(stream[n-1-k])));
    end
    return acc;
  endfunction

  function automatic void check(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic logic [DW-1:0] rand_val();
    case ($urandom_range(2))
      0:       return DW'(int'($urandom_range(4000)) - 2000);
      1:       return DW'($urandom());
      default: return 32'h8000_0000 | DW'($urandom_range(15));
    endcase
  endfunction

  // ---------------- upstream fifo models ----------------
  always @(posedge clock) begin
    #1;
    if (pop_seen && in_q.size() > 0) void'(in_q.pop_front());
    if (r_pop_seen && r_in_q.size() > 0) void'(r_in_q.pop_front());
    pop_seen   = 1'b0;
    r_pop_seen = 1'b0;
    in_empty   = (in_q.size() == 0) || stall_in;
    in_dout    = (in_q.size() > 0) ? in_q[0] : '0;
    r_in_empty = (r_in_q.size() == 0);
    r_in_dout  = (r_in_q.size() > 0) ? r_in_q[0] : '0;
  end

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    logic [DW-1:0] e;
    pop_seen   = in_rd_en;
    r_pop_seen = r_in_rd_en;
    if (reset_n) begin
      checks++;
      if ((in_rd_en && in_empty) || (out_wr_en && out_full) || (in_rd_en && out_wr_en)) begin
        errors++;
        $display("FAIL protocol: rd_en=%b empty=%b wr_en=%b full=%b",
                 in_rd_en, in_empty, out_wr_en, out_full);
      end
      if (out_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_push: got %h expected no output", out_din);
        end else begin
          e = exp_q.pop_front();
          check("out_din", out_din, e);
        end
      end
      if (r_out_wr_en) begin
        if (r_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_push_rnd: got %h expected no output", r_out_din);
        end else begin
          e = r_exp_q.pop_front();
          check("rnd_out_din", r_out_din, e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push_raw(input logic [DW-1:0] v);
    in_q.push_back(v);
    stream.push_back(v);
  endtask

  task automatic push_sample(input logic [DW-1:0] v);
    push_raw(v);
    if (stream.size() % int'(DECIM) == 0) exp_q.push_back(fir_ref());
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || r_exp_q.size() != 0 || in_q.size() != 0 ||
            r_in_q.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_%s: got %0d outputs pending expected 0", tag, exp_q.size() + r_exp_q.size());
      exp_q.delete();
      r_exp_q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, lat;
    bit done;
    logic [DW-1:0] v;

    // Reset with data waiting upstream: strobes must stay low.
    push_raw(32'd1024);
    repeat (2) tick();
    @(negedge clock);
    check("reset_rd_en", DW'(in_rd_en), '0);
    check("reset_wr_en", DW'(out_wr_en), '0);
    check("reset_out_din", out_din, '0);
    tick();
    reset_n = 1'b1;

    // Impulse.
    for (int i = 0; i < 5; i++) push_raw('0);
    exp_q.push_back(32'd2048);
    exp_q.push_back(32'd4096);
    exp_q.push_back(32'd0);
    wait_drain("impulse");

    // Floor rounding on the DECIM=1 instance.
    r_in_q.push_back(32'hFFFF_FFFF);
    r_exp_q.push_back(32'hFFFF_FFFF);
    r_in_q.push_back(32'd1);
    r_exp_q.push_back(32'd0);
    r_in_q.push_back(32'hFFFF_FFFD);
    r_exp_q.push_back(32'hFFFF_FFFE);
    for (int i = 0; i < 12; i++) begin
      v = rand_val();
      r_in_q.push_back(v);
      r_exp_q.push_back(deq_ref(512, longint'($signed(v))));
    end
    wait_drain("round");

    // Wrap: 3*7FFFFFFF then 7*7FFFFFFF modulo 2^32.
    push_raw(32'h7FFF_FFFF);
    push_raw(32'h7FFF_FFFF);
    push_raw('0);
    push_raw('0);
    push_raw('0);
    push_raw('0);
    exp_q.push_back(32'h7FFF_FFFD);
    exp_q.push_back(32'h7FFF_FFF9);
    exp_q.push_back(32'd0);
    wait_drain("wrap");

    // Backpressure: result held in S_WRITE, no pops, push on release.
    out_full = 1'b1;
    push_raw(32'd5);
    push_raw(32'd7);
    push_raw(32'd9);
    push_raw(32'd11);
    exp_q.push_back(32'd17);
    exp_q.push_back(32'd70);
    repeat (12) tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_wr_en", DW'(out_wr_en), '0);
      check("bp_rd_en", DW'(in_rd_en), '0);
      check("bp_out_din", out_din, 32'd17);
    end
    tick();
    out_full = 1'b0;
    @(negedge clock);
    check("bp_release_push", DW'(out_wr_en), 32'd1);
    wait_drain("backpressure");

    // Starvation between the two pops of a pair.
    push_raw(32'd3);
    repeat (3) tick();
    stall_in = 1'b1;
    push_raw(32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("starve_rd_en", DW'(in_rd_en), '0);
      check("starve_wr_en", DW'(out_wr_en), '0);
    end
    tick();
    stall_in = 1'b0;
    exp_q.push_back(32'd79);
    wait_drain("starve");

    // Reset in the middle of S_MAC.
    push_raw(32'd100);
    push_raw(32'd200);
    repeat (4) tick();
    push_raw(32'd300);
    tick();
    reset_n = 1'b0;
    #1;
    check("midreset_out_din", out_din, '0);
    check("midreset_wr_en", DW'(out_wr_en), '0);
    in_q.delete();
    stream.delete();
    exp_q.delete();
    repeat (2) tick();
    @(negedge clock);
    check("midreset_rd_en", DW'(in_rd_en), '0);
    tick();
    reset_n = 1'b1;

    // Impulse again, with latency from the DECIM-th pop to the push.
    push_raw(32'd1024);
    push_raw('0);
    exp_q.push_back(32'd2048);
    pops = 0;
    lat  = 0;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clock);
      if (pops == int'(DECIM)) begin
        lat++;
        if (out_wr_en) done = 1'b1;
      end else if (in_rd_en) begin
        pops++;
      end
    end
    check("latency", DW'(lat), DW'(TAPS + 1));
    tick();
    for (int i = 0; i < 4; i++) push_raw('0);
    exp_q.push_back(32'd4096);
    exp_q.push_back(32'd0);
    wait_drain("impulse2");

    // Randomised traffic with upstream stalls and downstream backpressure.
    for (int i = 0; i < 80; i++) begin
      push_sample(rand_val());
      tick();
      stall_in = ($urandom_range(3) == 0);
      out_full = ($urandom_range(2) == 0);
      if ($urandom_range(1) == 1) tick();
    end
    stall_in = 1'b0;
    out_full = 1'b0;
    wait_drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
